// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Multi-beat memory access controller. Accepts one core request
//            for 1..2^BEAT_W consecutive bytes and sequences the bus beats.
//            Each beat has programmable wait states, a bus_rdy stretch and
//            optional 256-byte page-wrap address increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int BEAT_W = 2,
    parameter int WAIT_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic                        we,
    input  logic                        src_pc,
    input  logic [AW-1:0]               pc,
    input  logic [AW-1:0]               addr,
    input  logic [BEAT_W-1:0]           len,
    input  logic [WAIT_W-1:0]           waits,
    input  logic                        page_wrap,
    input  logic [DW*(2**BEAT_W)-1:0]   wdata,
    output logic                        busy,
    output logic                        done,
    output logic [DW*(2**BEAT_W)-1:0]   rdata,
    output logic [AW-1:0]               bus_addr,
    output logic                        bus_we,
    output logic                        bus_oe,
    output logic [DW-1:0]               bus_dout,
    input  logic [DW-1:0]               bus_din,
    input  logic                        bus_rdy
);

    localparam int NBEATS = 2**BEAT_W;
    localparam int WDW    = DW*NBEATS;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic [AW-1:0]      cur_addr_q, cur_addr_d;
    logic               we_l_q,    we_l_d;
    logic [BEAT_W-1:0]  len_l_q,   len_l_d;
    logic [WAIT_W-1:0]  waits_l_q, waits_l_d;
    logic               pw_l_q,    pw_l_d;
    logic [WDW-1:0]     wdata_l_q, wdata_l_d;
    logic [BEAT_W-1:0]  beat_q,    beat_d;
    logic [WAIT_W-1:0]  wcnt_q,    wcnt_d;
    logic [WDW-1:0]     rdata_q,   rdata_d;
    logic               done_q,    done_d;

    logic [AW-1:0]      addr_inc;

    // Next beat address: either full-width increment or wrap inside the 256-byte page.
    always_comb begin
        if (pw_l_q) begin
            addr_inc = {cur_addr_q[AW-1:8], cur_addr_q[7:0] + 8'd1};
        end else begin
            addr_inc = cur_addr_q + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // State and datapath registers; reset clears everything including a transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            we_l_q     <= 1'b0;
            len_l_q    <= '0;
            waits_l_q  <= '0;
            pw_l_q     <= 1'b0;
            wdata_l_q  <= '0;
            beat_q     <= '0;
            wcnt_q     <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            we_l_q     <= we_l_d;
            len_l_q    <= len_l_d;
            waits_l_q  <= waits_l_d;
            pw_l_q     <= pw_l_d;
            wdata_l_q  <= wdata_l_d;
            beat_q     <= beat_d;
            wcnt_q     <= wcnt_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
        end
    end

    // Request acceptance, wait-state countdown and beat sequencing.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        we_l_d     = we_l_q;
        len_l_d    = len_l_q;
        waits_l_d  = waits_l_q;
        pw_l_d     = pw_l_q;
        wdata_l_d  = wdata_l_q;
        beat_d     = beat_q;
        wcnt_d     = wcnt_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d    = ACCESS;
                    cur_addr_d = src_pc ? pc : addr;
                    we_l_d     = we;
                    len_l_d    = len;
                    waits_l_d  = waits;
                    pw_l_d     = page_wrap;
                    wdata_l_d  = wdata;
                    beat_d     = '0;
                    wcnt_d     = waits;
                    // A read starts from a clean buffer so unused beats read back as zero.
                    if (!we) begin
                        rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
                end else if (bus_rdy) begin
                    if (!we_l_q) begin
                        rdata_d[beat_q*DW +: DW] = bus_din;
                    end
                    if (beat_q == len_l_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d     = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
                        cur_addr_d = addr_inc;
                        wcnt_d     = waits_l_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registers only; bus_addr/bus_dout naturally hold in IDLE.
    always_comb begin
        busy     = (state_q == ACCESS);
        bus_we   = (state_q == ACCESS) && we_l_q;
        bus_oe   = (state_q == ACCESS) && we_l_q;
        bus_addr = cur_addr_q;
        bus_dout = wdata_l_q[beat_q*DW +: DW];
        done     = done_q;
        rdata    = rdata_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl with a transaction-level
//            reference model (address list, captured bytes, cycle counts).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int BW  = 2;
    localparam int WW  = 4;
    localparam int WDW = 32;

    logic            clk;
    logic            rst;
    logic            req;
    logic            we;
    logic            src_pc;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   len;
    logic [WW-1:0]   waits;
    logic            page_wrap;
    logic [WDW-1:0]  wdata;
    logic            busy;
    logic            done;
    logic [WDW-1:0]  rdata;
    logic [AW-1:0]   bus_addr;
    logic            bus_we;
    logic            bus_oe;
    logic [DW-1:0]   bus_dout;
    logic [DW-1:0]   bus_din;
    logic            bus_rdy;

    int errors = 0;
    int checks = 0;
    logic [WDW-1:0] exp_rdata;

    mem_access_ctrl #(.AW(AW), .DW(DW), .BEAT_W(BW), .WAIT_W(WW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .src_pc(src_pc),
        .pc(pc), .addr(addr), .len(len), .waits(waits), .page_wrap(page_wrap),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_oe(bus_oe),
        .bus_dout(bus_dout), .bus_din(bus_din), .bus_rdy(bus_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address rule: full 16-bit increment, or low byte increments within the page.
    function automatic logic [15:0] next_addr(input logic [15:0] a, input bit pw);
        int v;
        if (pw) v = (int'(a) & 32'hFF00) | ((int'(a) + 1) & 32'h00FF);
        else    v = (int'(a) + 1) % 65536;
        return v[15:0];
    endfunction

    // Present a request at the current negedge; returns nothing, acceptance is the next posedge.
    task automatic start_txn(input bit twe, input bit spc, input logic [15:0] a,
                             input int tlen, input int twaits, input bit pw,
                             input logic [31:0] wd);
        logic [1:0] l2;
        logic [3:0] w4;
        l2 = tlen[1:0];
        w4 = twaits[3:0];
        req = 1'b1; we = twe; src_pc = spc;
        pc   = spc ? a : 16'($urandom);
        addr = spc ? 16'($urandom) : a;
        len = l2; waits = w4; page_wrap = pw; wdata = wd;
    endtask

    // Follow one accepted transaction cycle by cycle against the model.
    task automatic run_body(input bit twe, input logic [15:0] start, input int tlen,
                            input int twaits, input bit pw, input logic [31:0] twdata,
                            input int stall0, input int prob, input bit poke,
                            input bit chain, output int cyc);
        logic [15:0] a;
        logic [15:0] lasta;
        logic [7:0]  din;
        logic [7:0]  expb;
        bit          rdy;
        bit          abort;
        int          c;
        int          forced;
        int          st;
        @(posedge clk);
        if (!twe) exp_rdata = '0;
        a = start; lasta = start; cyc = 0; abort = 0;
        for (int i = 0; i <= tlen; i++) begin
            c = 0; forced = (i == 0) ? stall0 : 0; st = 0;
            forever begin
                @(negedge clk);
                if (cyc == 0) begin
                    req = poke; we = $urandom_range(0, 1); src_pc = $urandom_range(0, 1);
                    pc = 16'($urandom); addr = 16'($urandom); len = 2'($urandom);
                    waits = 4'($urandom); page_wrap = $urandom_range(0, 1); wdata = $urandom;
                end else begin
                    req = 1'b0;
                end
                din = 8'($urandom);
                bus_din = din;
                if (c < twaits)                                 rdy = $urandom_range(0, 1);
                else if (forced > 0)                            begin rdy = 0; forced--; end
                else if (st < 5 && $urandom_range(0, 99) < prob) begin rdy = 0; st++; end
                else                                            rdy = 1;
                bus_rdy = rdy;
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL beat_busy: got %b expected 1 (beat %0d)", busy, i); end
                checks++;
                if (bus_addr !== a) begin errors++; $display("FAIL beat_addr: got %h expected %h (beat %0d)", bus_addr, a, i); end
                checks++;
                if (bus_we !== twe || bus_oe !== twe) begin errors++; $display("FAIL beat_we_oe: got %b/%b expected %b", bus_we, bus_oe, twe); end
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL beat_done: got %b expected 0", done); end
                if (twe) begin
                    expb = twdata[i*8 +: 8];
                    checks++;
                    if (bus_dout !== expb) begin errors++; $display("FAIL beat_dout: got %h expected %h (beat %0d)", bus_dout, expb, i); end
                end
                cyc++;
                if (c >= twaits && rdy) begin
                    if (!twe) exp_rdata[i*8 +: 8] = din;
                    break;
                end
                c++;
                if (c > 64) begin
                    errors++; $display("FAIL beat_timeout: got %0d cycles expected at most 64", c);
                    abort = 1;
                    break;
                end
            end
            if (abort) break;
            lasta = a;
            a = next_addr(a, pw);
        end
        @(negedge clk);
        req = 1'b0;
        bus_rdy = 1'b0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b expected 1", done); end
        checks++;
        if (busy !== 1'b0 || bus_we !== 1'b0 || bus_oe !== 1'b0) begin
            errors++; $display("FAIL done_idle: got busy/we/oe %b%b%b expected 000", busy, bus_we, bus_oe);
        end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL rdata: got %h expected %h", rdata, exp_rdata); end
        checks++;
        if (bus_addr !== lasta) begin errors++; $display("FAIL addr_hold: got %h expected %h", bus_addr, lasta); end
        if (!chain) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL after_done: got done/busy %b%b expected 00", done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 0; we = 0; src_pc = 0; pc = '0; addr = '0; len = '0;
        waits = '0; page_wrap = 0; wdata = '0; bus_din = '0; bus_rdy = 0;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, bus_we, bus_oe} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, bus_we, bus_oe});
        end
        checks++;
        if (bus_addr !== 16'h0000 || bus_dout !== 8'h00 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected 0 0 0", bus_addr, bus_dout, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int cyc;
        start_txn(0, 1, 16'hC000, 0, 0, 0, 32'hDEADBEEF);
        run_body(0, 16'hC000, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, cyc);
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", cyc); end
    endtask

    task automatic test_write_burst();
        int cyc;
        start_txn(1, 0, 16'h0200, 3, 2, 0, 32'h44332211);
        run_body(1, 16'h0200, 3, 2, 0, 32'h44332211, 0, 0, 0, 0, cyc);
        checks++;
        if (cyc !== 12) begin errors++; $display("FAIL burst_latency: got %0d expected 12", cyc); end
    endtask

    task automatic test_page_wrap();
        int cyc;
        start_txn(0, 0, 16'h12FF, 1, 0, 1, 32'h0);
        run_body(0, 16'h12FF, 1, 0, 1, 32'h0, 0, 0, 0, 0, cyc);
        start_txn(0, 0, 16'h12FF, 1, 0, 0, 32'h0);
        run_body(0, 16'h12FF, 1, 0, 0, 32'h0, 0, 0, 0, 0, cyc);
        start_txn(0, 1, 16'hFFFF, 1, 1, 0, 32'h0);
        run_body(0, 16'hFFFF, 1, 1, 0, 32'h0, 0, 0, 0, 0, cyc);
        start_txn(1, 0, 16'hABFE, 3, 0, 1, 32'hA1B2C3D4);
        run_body(1, 16'hABFE, 3, 0, 1, 32'hA1B2C3D4, 0, 0, 0, 0, cyc);
    endtask

    task automatic test_ready_stretch();
        int cyc;
        start_txn(0, 0, 16'h3456, 1, 0, 0, 32'h0);
        run_body(0, 16'h3456, 1, 0, 0, 32'h0, 3, 0, 1, 0, cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL stretch_latency: got %0d expected 5", cyc); end
    endtask

    task automatic test_reset_mid();
        start_txn(1, 0, 16'h4000, 3, 1, 0, 32'h55667788);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 1'b0; bus_rdy = 1'b1;
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        exp_rdata = '0;
        checks++;
        if ({busy, done, bus_we, bus_oe} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_ctrl: got %b expected 0000", {busy, done, bus_we, bus_oe});
        end
        checks++;
        if (bus_addr !== 16'h0000 || bus_dout !== 8'h00 || rdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset_data: got %h %h %h expected 0 0 0", bus_addr, bus_dout, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_no_done: got done/busy %b%b expected 00", done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_txn(0, 0, 16'h0800, 1, 1, 0, 32'h0);
        run_body(0, 16'h0800, 1, 1, 0, 32'h0, 0, 0, 0, 1, cyc);
        start_txn(1, 1, 16'h09FE, 2, 0, 1, 32'h00CCBBAA);
        run_body(1, 16'h09FE, 2, 0, 1, 32'h00CCBBAA, 0, 0, 0, 1, cyc);
        start_txn(0, 0, 16'h0A10, 0, 0, 0, 32'h0);
        run_body(0, 16'h0A10, 0, 0, 0, 32'h0, 0, 0, 0, 0, cyc);
    endtask

    task automatic test_random();
        int cyc;
        for (int n = 0; n < 30; n++) begin
            bit          twe, spc, pw, poke, chain;
            logic [15:0] a;
            logic [31:0] wd;
            int          tlen, tw;
            twe = $urandom_range(0, 1); spc = $urandom_range(0, 1); pw = $urandom_range(0, 1);
            poke = $urandom_range(0, 1); chain = (n == 29) ? 1'b0 : 1'($urandom_range(0, 1));
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[7:0] = 8'hFE;
            wd = $urandom; tlen = $urandom_range(0, 3); tw = $urandom_range(0, 3);
            start_txn(twe, spc, a, tlen, tw, pw, wd);
            run_body(twe, a, tlen, tw, pw, wd, 0, 30, poke, chain, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_page_wrap();
        test_ready_stretch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
